// File: rtl/id_pkg.sv
// Shared types for the decode-to-execute operand stage: register-zero constant,
// forwarding-select record and the ID/EX bundle layout for the default configuration.
package id_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int REG_AW_DEF  = 5;
  localparam int CTRL_W_DEF  = 24;
  localparam int FWD_IDX_W   = 4;

  localparam logic [REG_AW_DEF-1:0] REG_X0 = '0;

  // Result of one operand's forwarding search: which source won and whether it is usable yet.
  typedef struct packed {
    logic [FWD_IDX_W-1:0] idx;
    logic                 hit;
    logic                 pending;
  } fwd_sel_t;

  typedef struct packed {
    logic [CTRL_W_DEF-1:0] ctrl;
    logic [XLEN_DEF-1:0]   rs1_data;
    logic [XLEN_DEF-1:0]   rs2_data;
    logic [REG_AW_DEF-1:0] rd_addr;
    logic [XLEN_DEF-1:0]   imm;
    logic [XLEN_DEF-1:0]   pc;
  } id_ex_bundle_t;

endpackage

// File: rtl/id_operand_stage_if.sv
// Decode/forward/execute signal bundle of the operand stage; master drives decode side, slave is the stage.
interface id_operand_stage_if #(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 2,
  parameter int CTRL_W  = 24
);
  logic                      flush_i;
  logic                      dec_valid_i;
  logic                      dec_ready_o;
  logic [CTRL_W-1:0]         dec_ctrl_i;
  logic [REG_AW-1:0]         dec_rs1_addr_i;
  logic [REG_AW-1:0]         dec_rs2_addr_i;
  logic                      dec_rs1_used_i;
  logic                      dec_rs2_used_i;
  logic [REG_AW-1:0]         dec_rd_addr_i;
  logic [XLEN-1:0]           dec_imm_i;
  logic [XLEN-1:0]           dec_pc_i;
  logic [XLEN-1:0]           rf_rs1_data_i;
  logic [XLEN-1:0]           rf_rs2_data_i;
  logic [NUM_FWD-1:0]        fwd_valid_i;
  logic [NUM_FWD-1:0]        fwd_pending_i;
  logic [NUM_FWD*REG_AW-1:0] fwd_rd_addr_i;
  logic [NUM_FWD*XLEN-1:0]   fwd_data_i;
  logic                      ex_valid_o;
  logic                      ex_ready_i;
  logic [CTRL_W-1:0]         ex_ctrl_o;
  logic [XLEN-1:0]           ex_rs1_data_o;
  logic [XLEN-1:0]           ex_rs2_data_o;
  logic [REG_AW-1:0]         ex_rd_addr_o;
  logic [XLEN-1:0]           ex_imm_o;
  logic [XLEN-1:0]           ex_pc_o;
  logic                      hazard_stall_o;

  modport master (
    output flush_i, dec_valid_i, dec_ctrl_i, dec_rs1_addr_i, dec_rs2_addr_i,
           dec_rs1_used_i, dec_rs2_used_i, dec_rd_addr_i, dec_imm_i, dec_pc_i,
           rf_rs1_data_i, rf_rs2_data_i, fwd_valid_i, fwd_pending_i,
           fwd_rd_addr_i, fwd_data_i, ex_ready_i,
    input  dec_ready_o, ex_valid_o, ex_ctrl_o, ex_rs1_data_o, ex_rs2_data_o,
           ex_rd_addr_o, ex_imm_o, ex_pc_o, hazard_stall_o
  );

  modport slave (
    input  flush_i, dec_valid_i, dec_ctrl_i, dec_rs1_addr_i, dec_rs2_addr_i,
           dec_rs1_used_i, dec_rs2_used_i, dec_rd_addr_i, dec_imm_i, dec_pc_i,
           rf_rs1_data_i, rf_rs2_data_i, fwd_valid_i, fwd_pending_i,
           fwd_rd_addr_i, fwd_data_i, ex_ready_i,
    output dec_ready_o, ex_valid_o, ex_ctrl_o, ex_rs1_data_o, ex_rs2_data_o,
           ex_rd_addr_o, ex_imm_o, ex_pc_o, hazard_stall_o
  );
endinterface

// File: rtl/id_fwd_mux.sv
// Priority forwarding for one source operand: lowest-index matching producer wins,
// register zero always reads as zero, hazard when the winner's result is still pending.
module id_fwd_mux
  import id_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 2
) (
  input  logic [REG_AW-1:0]         rs_addr,
  input  logic                      rs_used,
  input  logic [XLEN-1:0]           rf_data,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD-1:0]        fwd_pending,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_rd_addr,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
  output logic [XLEN-1:0]           data,
  output logic                      hazard
);

  fwd_sel_t sel;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sel = '0;
    // Scan from oldest to youngest so the youngest match is the last one written.
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (rs_used && fwd_valid[k]
          && fwd_rd_addr[k*REG_AW +: REG_AW] != REG_AW'(REG_X0)
          && fwd_rd_addr[k*REG_AW +: REG_AW] == rs_addr) begin
        sel.idx     = FWD_IDX_W'(k);
        sel.hit     = 1'b1;
        sel.pending = fwd_pending[k];
      end
    end
  end

  always_comb begin
    data = rf_data;
    for (int k = 0; k < NUM_FWD; k++) begin
      if (sel.hit && sel.idx == FWD_IDX_W'(k)) data = fwd_data[k*XLEN +: XLEN];
    end
    if (rs_addr == REG_AW'(REG_X0)) data = '0;
  end

  assign hazard = sel.hit & sel.pending;

endmodule

// File: rtl/id_operand_stage.sv
// ID/EX operand stage: resolves rs1/rs2 through the forwarding network, interlocks on pending
// producers and registers the bundle into a valid/ready pipeline register. Option: ID_STALL_CNT_EN.
module id_operand_stage
  import id_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 2,
  parameter int CTRL_W  = 24
) (
  input  logic clk_i,
  input  logic rst_i,
  id_operand_stage_if.slave bus
`ifdef ID_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt_o
`endif
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [REG_AW-1:0] rd_addr;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
  } bundle_t;

  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            rs1_hazard;
  logic            rs2_hazard;
  logic            hazard;
  logic            transfer;
  logic            ex_valid;
  bundle_t         ex_q;
  bundle_t         ex_d;

  id_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_fwd_rs1 (
    .rs_addr     (bus.dec_rs1_addr_i),
    .rs_used     (bus.dec_rs1_used_i),
    .rf_data     (bus.rf_rs1_data_i),
    .fwd_valid   (bus.fwd_valid_i),
    .fwd_pending (bus.fwd_pending_i),
    .fwd_rd_addr (bus.fwd_rd_addr_i),
    .fwd_data    (bus.fwd_data_i),
    .data        (rs1_data),
    .hazard      (rs1_hazard)
  );

  id_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_fwd_rs2 (
    .rs_addr     (bus.dec_rs2_addr_i),
    .rs_used     (bus.dec_rs2_used_i),
    .rf_data     (bus.rf_rs2_data_i),
    .fwd_valid   (bus.fwd_valid_i),
    .fwd_pending (bus.fwd_pending_i),
    .fwd_rd_addr (bus.fwd_rd_addr_i),
    .fwd_data    (bus.fwd_data_i),
    .data        (rs2_data),
    .hazard      (rs2_hazard)
  );

  assign hazard             = rs1_hazard | rs2_hazard;
  // Flush always drains the input, even while interlocked.
  assign bus.dec_ready_o    = bus.flush_i | (~hazard & (~ex_valid | bus.ex_ready_i));
  assign bus.hazard_stall_o = bus.dec_valid_i & hazard & ~bus.flush_i;
  assign transfer           = bus.dec_valid_i & bus.dec_ready_o & ~bus.flush_i;

  always_comb begin
    ex_d          = '0;
    ex_d.ctrl     = bus.dec_ctrl_i;
    ex_d.rs1_data = rs1_data;
    ex_d.rs2_data = rs2_data;
    ex_d.rd_addr  = bus.dec_rd_addr_i;
    ex_d.imm      = bus.dec_imm_i;
    ex_d.pc       = bus.dec_pc_i;
  end

  // NOTE: state uses non-blocking assignments; the payload is reset too because EX sees it directly.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_valid <= 1'b0;
      ex_q     <= '0;
    end else if (bus.flush_i) begin
      ex_valid <= 1'b0;
    end else if (transfer) begin
      ex_valid <= 1'b1;
      ex_q     <= ex_d;
    end else if (bus.ex_ready_i) begin
      ex_valid <= 1'b0;
    end
  end

  assign bus.ex_valid_o    = ex_valid;
  assign bus.ex_ctrl_o     = ex_q.ctrl;
  assign bus.ex_rs1_data_o = ex_q.rs1_data;
  assign bus.ex_rs2_data_o = ex_q.rs2_data;
  assign bus.ex_rd_addr_o  = ex_q.rd_addr;
  assign bus.ex_imm_o      = ex_q.imm;
  assign bus.ex_pc_o       = ex_q.pc;

`ifdef ID_STALL_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
    end else if (bus.hazard_stall_o && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt;
`endif

endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench for id_operand_stage: directed vectors plus a per-cycle reference model compare.
module tb_id_operand_stage;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NF   = 2;
  localparam int CW   = 24;

  logic clk_i = 1'b0;
  logic rst_i;
  int   checks = 0;
  int   errors = 0;
  logic cmp_en = 1'b0;

  always #5 clk_i = ~clk_i;

  id_operand_stage_if #(.XLEN(XLEN), .REG_AW(AW), .NUM_FWD(NF), .CTRL_W(CW)) bus ();

`ifdef ID_STALL_CNT_EN
  logic [31:0] stall_cnt_o;
`endif

  id_operand_stage #(.XLEN(XLEN), .REG_AW(AW), .NUM_FWD(NF), .CTRL_W(CW)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
`ifdef ID_STALL_CNT_EN
    ,
    .stall_cnt_o (stall_cnt_o)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic            m_valid;
  logic [CW-1:0]   m_ctrl;
  logic [XLEN-1:0] m_rs1, m_rs2, m_imm, m_pc;
  logic [AW-1:0]   m_rd;

  function automatic void resolve(input logic [AW-1:0] rs, input logic used,
                                  input logic [XLEN-1:0] rf,
                                  output logic [XLEN-1:0] d, output logic p);
    d = rf;
    p = 1'b0;
    if (rs == 0) begin
      d = '0;
      return;
    end
    if (!used) return;
    for (int k = 0; k < NF; k++) begin
      if (bus.fwd_valid_i[k] && bus.fwd_rd_addr_i[k*AW +: AW] == rs) begin
        d = bus.fwd_data_i[k*XLEN +: XLEN];
        p = bus.fwd_pending_i[k];
        return;
      end
    end
  endfunction

  function automatic void model_comb(output logic rdy, output logic stall,
                                     output logic [XLEN-1:0] d1, output logic [XLEN-1:0] d2);
    logic p1, p2, haz;
    resolve(bus.dec_rs1_addr_i, bus.dec_rs1_used_i, bus.rf_rs1_data_i, d1, p1);
    resolve(bus.dec_rs2_addr_i, bus.dec_rs2_used_i, bus.rf_rs2_data_i, d2, p2);
    haz   = p1 | p2;
    rdy   = bus.flush_i | (!haz && (!m_valid || bus.ex_ready_i));
    stall = bus.dec_valid_i && haz && !bus.flush_i;
  endfunction

  always @(posedge clk_i) begin
    logic rdy, stall;
    logic [XLEN-1:0] d1, d2;
    model_comb(rdy, stall, d1, d2);
    if (rst_i) begin
      m_valid <= 1'b0;
      m_ctrl <= '0; m_rs1 <= '0; m_rs2 <= '0; m_imm <= '0; m_pc <= '0; m_rd <= '0;
    end else if (bus.flush_i) begin
      m_valid <= 1'b0;
    end else if (bus.dec_valid_i && rdy) begin
      m_valid <= 1'b1;
      m_ctrl <= bus.dec_ctrl_i; m_rs1 <= d1; m_rs2 <= d2;
      m_imm <= bus.dec_imm_i; m_pc <= bus.dec_pc_i; m_rd <= bus.dec_rd_addr_i;
    end else if (bus.ex_ready_i) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk_i) begin
    logic rdy, stall;
    logic [XLEN-1:0] d1, d2;
    if (cmp_en) begin
      model_comb(rdy, stall, d1, d2);
      check("dec_ready", 64'(bus.dec_ready_o), 64'(rdy));
      check("hazard_stall", 64'(bus.hazard_stall_o), 64'(stall));
      check("ex_valid", 64'(bus.ex_valid_o), 64'(m_valid));
      if (m_valid) begin
        check("ex_ctrl", 64'(bus.ex_ctrl_o), 64'(m_ctrl));
        check("ex_rs1", 64'(bus.ex_rs1_data_o), 64'(m_rs1));
        check("ex_rs2", 64'(bus.ex_rs2_data_o), 64'(m_rs2));
        check("ex_rd", 64'(bus.ex_rd_addr_o), 64'(m_rd));
        check("ex_imm", 64'(bus.ex_imm_o), 64'(m_imm));
        check("ex_pc", 64'(bus.ex_pc_o), 64'(m_pc));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    bus.flush_i = 0; bus.dec_valid_i = 0; bus.dec_ctrl_i = '0;
    bus.dec_rs1_addr_i = '0; bus.dec_rs2_addr_i = '0;
    bus.dec_rs1_used_i = 0; bus.dec_rs2_used_i = 0; bus.dec_rd_addr_i = '0;
    bus.dec_imm_i = '0; bus.dec_pc_i = '0;
    bus.rf_rs1_data_i = '0; bus.rf_rs2_data_i = '0;
    bus.fwd_valid_i = '0; bus.fwd_pending_i = '0;
    bus.fwd_rd_addr_i = '0; bus.fwd_data_i = '0;
    bus.ex_ready_i = 1;
  endtask

  task automatic dec(input logic [AW-1:0] rs1, input logic u1, input logic [AW-1:0] rs2,
                     input logic u2, input logic [XLEN-1:0] pc);
    bus.dec_valid_i = 1; bus.dec_rs1_addr_i = rs1; bus.dec_rs1_used_i = u1;
    bus.dec_rs2_addr_i = rs2; bus.dec_rs2_used_i = u2; bus.dec_pc_i = pc;
    bus.dec_ctrl_i = pc[CW-1:0] ^ 24'h5A5A5A; bus.dec_imm_i = pc + 32'h10;
    bus.dec_rd_addr_i = pc[AW-1:0];
  endtask

  task automatic fwd(input logic [NF-1:0] v, input logic [NF-1:0] p,
                     input logic [AW-1:0] rd0, input logic [AW-1:0] rd1,
                     input logic [XLEN-1:0] d0, input logic [XLEN-1:0] d1);
    bus.fwd_valid_i = v; bus.fwd_pending_i = p;
    bus.fwd_rd_addr_i = {rd1, rd0}; bus.fwd_data_i = {d1, d0};
  endtask

  initial begin
    idle();
    rst_i = 1;
    step(); step();
    check("rst ex_valid", 64'(bus.ex_valid_o), 64'd0);
    check("rst ex_pc", 64'(bus.ex_pc_o), 64'd0);
    check("rst ex_rs1", 64'(bus.ex_rs1_data_o), 64'd0);
    rst_i = 0;
    cmp_en = 1;
    step();

    // 1: youngest forwarding source wins
    dec(5'd5, 1, 5'd0, 0, 32'h40); bus.rf_rs1_data_i = 32'h1111;
    fwd(2'b11, 2'b00, 5'd5, 5'd5, 32'hAAAA, 32'hBBBB);
    step();
    check("t1 ex_valid", 64'(bus.ex_valid_o), 64'd1);
    check("t1 ex_rs1", 64'(bus.ex_rs1_data_o), 64'hAAAA);

    // 2: pending producer interlocks, bubble, then forwards once available
    dec(5'd0, 0, 5'd3, 1, 32'h44);
    fwd(2'b01, 2'b01, 5'd3, 5'd0, 32'h0, 32'h0);
    #1;
    check("t2 dec_ready", 64'(bus.dec_ready_o), 64'd0);
    check("t2 stall", 64'(bus.hazard_stall_o), 64'd1);
    step();
    check("t2 bubble", 64'(bus.ex_valid_o), 64'd0);
    fwd(2'b01, 2'b00, 5'd3, 5'd0, 32'h1234, 32'h0);
    step();
    check("t2 ex_rs2", 64'(bus.ex_rs2_data_o), 64'h1234);
    check("t2 ex_valid", 64'(bus.ex_valid_o), 64'd1);

    // 3: x0 reads zero; unused source ignores pending; younger ready result masks older pending
    dec(5'd0, 1, 5'd0, 0, 32'h48); bus.rf_rs1_data_i = 32'hDEAD;
    fwd(2'b01, 2'b00, 5'd0, 5'd0, 32'hFFFF, 32'h0);
    step();
    check("t3 x0", 64'(bus.ex_rs1_data_o), 64'd0);
    dec(5'd7, 0, 5'd0, 0, 32'h4C);
    fwd(2'b01, 2'b01, 5'd7, 5'd0, 32'h7, 32'h0);
    #1;
    check("t3 unused stall", 64'(bus.hazard_stall_o), 64'd0);
    check("t3 unused ready", 64'(bus.dec_ready_o), 64'd1);
    step();
    dec(5'd9, 1, 5'd0, 0, 32'h50);
    fwd(2'b11, 2'b10, 5'd9, 5'd9, 32'h9999, 32'h8888);
    #1;
    check("t3 mask stall", 64'(bus.hazard_stall_o), 64'd0);
    step();
    check("t3 mask data", 64'(bus.ex_rs1_data_o), 64'h9999);

    // 4: back-pressure holds the register stable
    fwd('0, '0, 5'd0, 5'd0, 32'h0, 32'h0);
    dec(5'd0, 0, 5'd0, 0, 32'h100);
    step();
    bus.ex_ready_i = 0;
    dec(5'd0, 0, 5'd0, 0, 32'h104);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4 dec_ready", 64'(bus.dec_ready_o), 64'd0);
      check("t4 hold pc", 64'(bus.ex_pc_o), 64'h100);
      check("t4 hold valid", 64'(bus.ex_valid_o), 64'd1);
      step();
    end
    bus.ex_ready_i = 1;
    #1;
    check("t4 release ready", 64'(bus.dec_ready_o), 64'd1);
    step();
    check("t4 next pc", 64'(bus.ex_pc_o), 64'h104);

    // 5: flush and reset drop both the held and incoming bundle
    dec(5'd0, 0, 5'd0, 0, 32'h200);
    bus.flush_i = 1;
    #1;
    check("t5 flush ready", 64'(bus.dec_ready_o), 64'd1);
    step();
    check("t5 flush valid", 64'(bus.ex_valid_o), 64'd0);
    bus.flush_i = 0;
    dec(5'd0, 0, 5'd0, 0, 32'h300);
    step();
    check("t5 load", 64'(bus.ex_pc_o), 64'h300);
    dec(5'd0, 0, 5'd0, 0, 32'h400);
    rst_i = 1;
    step();
    check("t5 rst valid", 64'(bus.ex_valid_o), 64'd0);
    check("t5 rst pc", 64'(bus.ex_pc_o), 64'd0);
    rst_i = 0;
    idle();
    step();

`ifdef ID_STALL_CNT_EN
    // 6: stall counter counts hazard cycles and saturates
    dec(5'd0, 0, 5'd3, 1, 32'h500);
    fwd(2'b01, 2'b01, 5'd3, 5'd0, 32'h0, 32'h0);
    repeat (4) step();
    check("t6 cnt4", 64'(stall_cnt_o), 64'd4);
    force dut.stall_cnt = 32'hFFFF_FFFF;
    step();
    release dut.stall_cnt;
    step();
    check("t6 saturate", 64'(stall_cnt_o), 64'hFFFF_FFFF);
    idle();
    step();
`endif

    // mixed vectors, checked each cycle against the model
    for (int i = 0; i < 40; i++) begin
      logic [AW-1:0] regs [4];
      regs[0] = 5'd0; regs[1] = 5'd3; regs[2] = 5'd5; regs[3] = 5'd7;
      dec(regs[$urandom_range(0, 3)], 1'($urandom_range(0, 1)),
          regs[$urandom_range(0, 3)], 1'($urandom_range(0, 1)), 32'($urandom));
      bus.dec_valid_i = ($urandom_range(0, 3) != 0);
      bus.rf_rs1_data_i = 32'($urandom); bus.rf_rs2_data_i = 32'($urandom);
      fwd(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0) ? 2'b01 : 2'b00,
          regs[$urandom_range(0, 3)], regs[$urandom_range(0, 3)], 32'($urandom), 32'($urandom));
      bus.ex_ready_i = ($urandom_range(0, 3) != 0);
      bus.flush_i = ($urandom_range(0, 9) == 0);
      step();
    end

    idle();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
